// File: rtl/stack_op_sequencer.sv
// Front-panel operand sequencer: turns one button press into a stack push, or into
// operand pops, an ALU operation and a result push, with underflow/overflow rejection.
module stack_op_sequencer #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        SW_W       = 16,
    parameter int unsigned        NUM_OPS    = 4,
    parameter logic [NUM_OPS-1:0] UNARY_MASK = '0,
    parameter int unsigned        MEM_LAT    = 1,
    parameter int unsigned        DEPTH_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SW_W-1:0]    switches,
    input  logic [NUM_OPS:0]   btns,
    input  logic [DATA_W-1:0]  mem_out,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DEPTH_W-1:0] stack_count,
    input  logic               stack_full,
    output logic               push,
    output logic               pop,
    output logic [DATA_W-1:0]  mem_in,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [NUM_OPS-1:0] op_sel,
    output logic               busy,
    output logic               err
);
    localparam int unsigned      CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [NUM_OPS:0] BTN_ONE  = (NUM_OPS + 1)'(1);

    typedef enum logic [3:0] {
        StIdle, StPopB, StWaitB, StPopA, StWaitA, StExec, StPush, StHold, StErr
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_q, push_d, pop_q, pop_d, busy_q, busy_d, err_q, err_d;
    logic [DATA_W-1:0]  mem_in_q, mem_in_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [NUM_OPS-1:0] op_sel_q, op_sel_d;

    logic one_hot, accept, is_push, is_unary, wait_done;

    always_comb begin
        one_hot   = (btns != '0) && ((btns & (btns - BTN_ONE)) == '0);
        accept    = (state_q == StIdle) && one_hot;
        is_push   = btns[0];
        is_unary  = |(btns[NUM_OPS:1] & UNARY_MASK);
        wait_done = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_in_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            op_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            mem_in_q <= mem_in_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            op_sel_q <= op_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_push) begin
                        state_d = stack_full ? StErr : StPush;
                    end else if (is_unary) begin
                        state_d = (stack_count == '0) ? StErr : StPopA;
                    end else begin
                        state_d = (stack_count < DEPTH_W'(2)) ? StErr : StPopB;
                    end
                end
            end
            StPopB: begin
                state_d = StWaitB;
                cnt_d   = '0;
            end
            StWaitB: begin
                if (wait_done) state_d = StPopA;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            StPopA: begin
                state_d = StWaitA;
                cnt_d   = '0;
            end
            StWaitA: begin
                if (wait_done) state_d = StExec;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            StExec:        state_d = StPush;
            StPush:        state_d = StHold;
            StHold, StErr: if (btns == '0) state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        push_d   = (state_d == StPush);
        pop_d    = (state_d == StPopA) || (state_d == StPopB);
        busy_d   = !(state_d inside {StIdle, StHold, StErr});
        err_d    = err_q;
        op_sel_d = op_sel_q;
        mem_in_d = mem_in_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        if (accept) begin
            err_d    = 1'b0;
            op_sel_d = btns[NUM_OPS:1];
        end
        if (state_d == StErr)                     err_d    = 1'b1;
        if (accept && is_push && !stack_full)     mem_in_d = DATA_W'(switches);
        if (state_q == StExec)                    mem_in_d = alu_out;
        // Only an accepted unary op goes straight from idle to the A pop.
        if (accept && state_d == StPopA)          alu_b_d  = '0;
        if (state_q == StWaitB && wait_done)      alu_b_d  = mem_out;
        if (state_q == StWaitA && wait_done)      alu_a_d  = mem_out;
    end

    assign push   = push_q;
    assign pop    = pop_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign mem_in = mem_in_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign op_sel = op_sel_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: two instances (read latency 1 and 3) share the panel inputs,
// each with its own stack memory and ALU, checked against a queue-based calculator model.
module tb_stack_op_sequencer;
    localparam int         STACK_MAX = 8;
    localparam logic [3:0] UNARY     = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switches;
    logic [4:0]  btns;

    logic [31:0] mem_out_w[2], alu_out_w[2], mem_in_w[2], alu_a_w[2], alu_b_w[2];
    logic [4:0]  cnt_w[2];
    logic        full_w[2], push_w[2], pop_w[2], busy_w[2], err_w[2];
    logic [3:0]  op_sel_w[2];

    always #5 clk = ~clk;

    stack_op_sequencer #(
        .DATA_W(32), .SW_W(16), .NUM_OPS(4), .UNARY_MASK(UNARY), .MEM_LAT(1), .DEPTH_W(5)
    ) dut0 (
        .clk(clk), .rst(rst), .switches(switches), .btns(btns), .mem_out(mem_out_w[0]),
        .alu_out(alu_out_w[0]), .stack_count(cnt_w[0]), .stack_full(full_w[0]),
        .push(push_w[0]), .pop(pop_w[0]), .mem_in(mem_in_w[0]), .alu_a(alu_a_w[0]),
        .alu_b(alu_b_w[0]), .op_sel(op_sel_w[0]), .busy(busy_w[0]), .err(err_w[0])
    );

    stack_op_sequencer #(
        .DATA_W(32), .SW_W(16), .NUM_OPS(4), .UNARY_MASK(UNARY), .MEM_LAT(3), .DEPTH_W(5)
    ) dut1 (
        .clk(clk), .rst(rst), .switches(switches), .btns(btns), .mem_out(mem_out_w[1]),
        .alu_out(alu_out_w[1]), .stack_count(cnt_w[1]), .stack_full(full_w[1]),
        .push(push_w[1]), .pop(pop_w[1]), .mem_in(mem_in_w[1]), .alu_a(alu_a_w[1]),
        .alu_b(alu_b_w[1]), .op_sel(op_sel_w[1]), .busy(busy_w[1]), .err(err_w[1])
    );

    function automatic logic [31:0] alu_f(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int sel_idx(input logic [3:0] s);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (s[i]) r = i;
        return r;
    endfunction

    // Stack memory per instance; read data appears after the instance's latency, junk otherwise.
    int          scnt[2];
    logic [31:0] stk[2][32];
    logic [31:0] dly[2][3];
    logic        env_clr;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (env_clr) begin
                scnt[k] <= 0;
            end else if (push_w[k] && scnt[k] < 32) begin
                stk[k][scnt[k]] <= mem_in_w[k];
                scnt[k]         <= scnt[k] + 1;
            end else if (pop_w[k] && scnt[k] > 0) begin
                scnt[k] <= scnt[k] - 1;
            end
            dly[k][0] <= (pop_w[k] && scnt[k] > 0) ? stk[k][scnt[k]-1] : $urandom();
            dly[k][1] <= dly[k][0];
            dly[k][2] <= dly[k][1];
        end
    end

    assign mem_out_w[0] = dly[0][0];
    assign mem_out_w[1] = dly[1][2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            alu_out_w[k] = alu_f(sel_idx(op_sel_w[k]), alu_a_w[k], alu_b_w[k]);
            cnt_w[k]     = 5'(scnt[k]);
            full_w[k]    = (scnt[k] >= STACK_MAX);
        end
    end

    // Calculator-level reference state.
    logic [31:0] mq[$];
    logic        err_e;
    logic [3:0]  op_sel_e;
    logic [31:0] mem_in_e, alu_a_e, alu_b_e;
    int          n_vec, n_err;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        err_e    = 1'b0;
        op_sel_e = '0;
        mem_in_e = '0;
        alu_a_e  = '0;
        alu_b_e  = '0;
    endtask

    task automatic check_idle_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_ctl%0d", tag, k),
                     {push_w[k], pop_w[k], busy_w[k], err_w[k], op_sel_w[k]}, '0);
            check_eq($sformatf("%s_data%0d", tag, k), {mem_in_w[k], alu_a_w[k], alu_b_w[k]}, '0);
        end
    endtask

    task automatic do_cmd(input logic [4:0] b, input logic [15:0] sw, input int rel,
                          input bit noisy);
        bit          acc, e, unary, is_push;
        int          op, ncyc, lat, x_pops, x_push, x_busy, x_pc, x_p2;
        logic [31:0] ra, rb, rr;
        int          pops[2], pop1[2], pop2[2], pushes[2], push_c[2], busy_n[2], excl[2];
        logic [31:0] pushed[2];

        acc     = $onehot(b);
        is_push = b[0];
        op      = 0;
        for (int i = 0; i < 4; i++) if (b[i+1]) op = i;
        unary = !is_push && UNARY[op];
        e     = 1'b0;
        rr    = '0;
        if (acc) begin
            err_e    = 1'b0;
            op_sel_e = b[4:1];
            if (is_push) begin
                if (mq.size() >= STACK_MAX) begin
                    e = 1'b1;
                end else begin
                    rr = {16'h0, sw};
                    mq.push_back(rr);
                    mem_in_e = rr;
                end
            end else if (mq.size() < (unary ? 1 : 2)) begin
                e = 1'b1;
            end else begin
                rb = unary ? 32'h0 : mq.pop_back();
                ra = mq.pop_back();
                rr = alu_f(op, ra, rb);
                mq.push_back(rr);
                alu_a_e  = ra;
                alu_b_e  = rb;
                mem_in_e = rr;
            end
            if (e) err_e = 1'b1;
        end

        for (int k = 0; k < 2; k++) begin
            pops[k] = 0; pop1[k] = 0; pop2[k] = 0; pushes[k] = 0;
            push_c[k] = 0; busy_n[k] = 0; excl[k] = 0; pushed[k] = '0;
        end

        @(negedge clk);
        btns     = b;
        switches = sw;
        ncyc     = ((rel > 10) ? rel : 10) + 3;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (pop_w[k]) begin
                    pops[k]++;
                    if (pops[k] == 1) pop1[k] = c;
                    if (pops[k] == 2) pop2[k] = c;
                end
                if (push_w[k]) begin
                    pushes[k]++;
                    push_c[k] = c;
                    pushed[k] = mem_in_w[k];
                end
                if (busy_w[k]) busy_n[k]++;
                if (push_w[k] && pop_w[k]) excl[k]++;
            end
            if (c >= rel)             btns = '0;
            else if (noisy && acc)    btns = 5'($urandom_range(1, 31));
        end

        for (int k = 0; k < 2; k++) begin
            lat    = (k == 0) ? 1 : 3;
            x_pops = 0; x_push = 0; x_busy = 0; x_pc = 0; x_p2 = 0;
            if (acc && !e) begin
                x_push = 1;
                if (is_push) begin
                    x_busy = 1; x_pc = 1;
                end else if (unary) begin
                    x_pops = 1; x_busy = 3 + lat; x_pc = 3 + lat;
                end else begin
                    x_pops = 2; x_p2 = 2 + lat; x_busy = 4 + 2 * lat; x_pc = 4 + 2 * lat;
                end
            end
            check_eq($sformatf("pops%0d", k), pops[k], x_pops);
            check_eq($sformatf("pushes%0d", k), pushes[k], x_push);
            check_eq($sformatf("busy_cycles%0d", k), busy_n[k], x_busy);
            check_eq($sformatf("push_pop_overlap%0d", k), excl[k], 0);
            if (x_pops > 0) check_eq($sformatf("pop1_cycle%0d", k), pop1[k], 1);
            if (x_pops > 1) check_eq($sformatf("pop2_cycle%0d", k), pop2[k], x_p2);
            if (x_push > 0) begin
                check_eq($sformatf("push_cycle%0d", k), push_c[k], x_pc);
                check_eq($sformatf("push_data%0d", k), pushed[k], rr);
            end
            check_eq($sformatf("err%0d", k), err_w[k], err_e);
            check_eq($sformatf("op_sel%0d", k), op_sel_w[k], op_sel_e);
            check_eq($sformatf("mem_in%0d", k), mem_in_w[k], mem_in_e);
            check_eq($sformatf("alu_a%0d", k), alu_a_w[k], alu_a_e);
            check_eq($sformatf("alu_b%0d", k), alu_b_w[k], alu_b_e);
            check_eq($sformatf("depth%0d", k), scnt[k], mq.size());
            if (mq.size() > 0 && scnt[k] > 0)
                check_eq($sformatf("top%0d", k), stk[k][scnt[k]-1], mq[mq.size()-1]);
        end
    endtask

    initial begin
        logic [4:0] rb5;
        int         sel;
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        env_clr  = 1'b1;
        btns     = '0;
        switches = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outs("reset");
        rst     = 1'b1;
        env_clr = 1'b0;

        do_cmd(5'b00001, 16'h0005, 10, 1'b0);   // held long: still a single push
        do_cmd(5'b00001, 16'h0003, 2, 1'b0);
        do_cmd(5'b00001, 16'h0005, 2, 1'b1);
        do_cmd(5'b00010, 16'h0000, 3, 1'b1);    // add 3 + 5
        do_cmd(5'b01000, 16'h0000, 2, 1'b0);    // xor leaves one entry
        do_cmd(5'b00100, 16'h0000, 2, 1'b0);    // binary underflow
        do_cmd(5'b00011, 16'h0009, 2, 1'b0);    // two buttons: ignored, err kept
        do_cmd(5'b00001, 16'h0007, 2, 1'b0);    // valid push clears err
        do_cmd(5'b10000, 16'h0000, 2, 1'b1);    // unary op3 on top=7
        do_cmd(5'b00011, 16'h0000, 2, 1'b0);
        repeat (9) do_cmd(5'b00001, 16'($urandom()), 1, 1'b0);  // runs into full

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                do_cmd(5'b00001, 16'($urandom()), $urandom_range(1, 12), 1'($urandom()));
            end else if (sel < 9) begin
                rb5 = 5'b00010 << $urandom_range(0, 3);
                do_cmd(rb5, 16'($urandom()), $urandom_range(1, 12), 1'($urandom()));
            end else begin
                do rb5 = 5'($urandom_range(0, 31)); while ($onehot(rb5));
                do_cmd(rb5, 16'($urandom()), 2, 1'b0);
            end
        end

        // Reset in the middle of a binary op.
        while (mq.size() < 2) do_cmd(5'b00001, 16'($urandom()), 1, 1'b0);
        @(negedge clk);
        btns = 5'b00100;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) btns = '0;
        end
        check_eq("midop_busy0", busy_w[0], 1'b1);
        check_eq("midop_busy1", busy_w[1], 1'b1);
        rst     = 1'b0;
        env_clr = 1'b1;
        #1;
        check_idle_outs("midop_reset");
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        env_clr = 1'b0;
        model_reset();
        do_cmd(5'b00001, 16'h1234, 2, 1'b0);
        do_cmd(5'b00010, 16'h0000, 2, 1'b0);    // underflow after reset
        do_cmd(5'b10000, 16'h0000, 3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
